// File: rtl/fg_sram_arbiter.sv
// Foreground SRAM arbiter: fixed-latency pipeline reads with absolute priority,
// capture writes buffered in a FIFO and drained into SRAM cycles left free by reads.
module fg_sram_arbiter #(
  parameter int unsigned PRECISION    = 12,
  parameter int unsigned RESOLUTION_X = 1920,
  parameter int unsigned RESOLUTION_Y = 1080,
  parameter int unsigned ADDR_WIDTH   = 21,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned WFIFO_DEPTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [PRECISION:0]      fg_pixel_request_x,
  input  logic signed [PRECISION:0]      fg_pixel_request_y,
  input  logic                           fg_pixel_request_active,
  output logic [15:0]                    fg_pixel_data,
  output logic                           fg_pixel_skip,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [PRECISION-1:0]           wr_x,
  input  logic [PRECISION-1:0]           wr_y,
  input  logic [15:0]                    wr_data,
  output logic [ADDR_WIDTH-1:0]          sram_addr,
  output logic                           sram_we,
  output logic [15:0]                    sram_wdata,
  input  logic [15:0]                    sram_rdata,
  output logic [$clog2(WFIFO_DEPTH):0]   wfifo_level,
  output logic [15:0]                    dropped_writes
);

  localparam int unsigned CW    = PRECISION + 1;
  localparam int unsigned PTR_W = $clog2(WFIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [ADDR_WIDTH-1:0] RES_X_A  = ADDR_WIDTH'(RESOLUTION_X);
  localparam logic [CW-1:0]         RES_X_C  = CW'(RESOLUTION_X);
  localparam logic [CW-1:0]         RES_Y_C  = CW'(RESOLUTION_Y);
  localparam logic [LVL_W-1:0]      FULL_LVL = LVL_W'(WFIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           data;
  } wentry_t;

  wentry_t              mem [WFIFO_DEPTH];
  wentry_t              head_c;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [READ_LATENCY:0] tag;

  logic                  rd_hit_c;
  logic [ADDR_WIDTH-1:0] raddr_c;
  logic                  wr_in_range_c;
  logic [ADDR_WIDTH-1:0] waddr_c;
  logic                  push_c;
  logic                  store_c;
  logic                  pop_c;

  // Negative coordinates have the sign bit set; otherwise compare the magnitude.
  assign rd_hit_c = fg_pixel_request_active
                    && !fg_pixel_request_x[PRECISION] && !fg_pixel_request_y[PRECISION]
                    && ({1'b0, fg_pixel_request_x[PRECISION-1:0]} < RES_X_C)
                    && ({1'b0, fg_pixel_request_y[PRECISION-1:0]} < RES_Y_C);

  assign raddr_c = ADDR_WIDTH'(fg_pixel_request_y[PRECISION-1:0]) * RES_X_A
                 + ADDR_WIDTH'(fg_pixel_request_x[PRECISION-1:0]);

  assign wr_in_range_c = ({1'b0, wr_x} < RES_X_C) && ({1'b0, wr_y} < RES_Y_C);
  assign waddr_c       = ADDR_WIDTH'(wr_y) * RES_X_A + ADDR_WIDTH'(wr_x);

  assign wr_ready = (wfifo_level != FULL_LVL);
  assign push_c   = wr_valid && wr_ready;
  assign store_c  = push_c && wr_in_range_c;
  assign pop_c    = !rd_hit_c && (wfifo_level != '0);
  assign head_c   = mem[rd_ptr];

  // FIFO storage is not reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (store_c) begin
      mem[wr_ptr] <= '{addr: waddr_c, data: wr_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag            <= '0;
      fg_pixel_data  <= '0;
      fg_pixel_skip  <= 1'b1;
      sram_addr      <= '0;
      sram_we        <= 1'b0;
      sram_wdata     <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      wfifo_level    <= '0;
      dropped_writes <= '0;
    end else begin
      // Every slot travels the same delay line, so responses keep request order.
      tag           <= {tag[READ_LATENCY-1:0], rd_hit_c};
      fg_pixel_skip <= !tag[READ_LATENCY];
      fg_pixel_data <= tag[READ_LATENCY] ? sram_rdata : 16'h0000;

      sram_we <= pop_c;
      if (pop_c) begin
        sram_addr  <= head_c.addr;
        sram_wdata <= head_c.data;
        rd_ptr     <= rd_ptr + PTR_W'(1);
      end else if (rd_hit_c) begin
        sram_addr <= raddr_c;
      end

      if (store_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      if (store_c && !pop_c) begin
        wfifo_level <= wfifo_level + LVL_W'(1);
      end else if (!store_c && pop_c) begin
        wfifo_level <= wfifo_level - LVL_W'(1);
      end

      if (push_c && !wr_in_range_c && (dropped_writes != 16'hFFFF)) begin
        dropped_writes <= dropped_writes + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fg_sram_arbiter.sv
// Bench for fg_sram_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fg_sram_arbiter;

  localparam int RES_X = 1920;
  localparam int RES_Y = 1080;
  localparam int RL    = 2;
  localparam int DEPTH = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [12:0] req_x;
  logic signed [12:0] req_y;
  logic               req_active;
  logic [15:0]        fg_pixel_data;
  logic               fg_pixel_skip;
  logic               wr_valid;
  logic               wr_ready;
  logic [11:0]        wr_x;
  logic [11:0]        wr_y;
  logic [15:0]        wr_data;
  logic [20:0]        sram_addr;
  logic               sram_we;
  logic [15:0]        sram_wdata;
  logic [15:0]        sram_rdata;
  logic [4:0]         wfifo_level;
  logic [15:0]        dropped_writes;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  fg_sram_arbiter dut (
    .clk                     (clk),
    .rst                     (rst),
    .fg_pixel_request_x      (req_x),
    .fg_pixel_request_y      (req_y),
    .fg_pixel_request_active (req_active),
    .fg_pixel_data           (fg_pixel_data),
    .fg_pixel_skip           (fg_pixel_skip),
    .wr_valid                (wr_valid),
    .wr_ready                (wr_ready),
    .wr_x                    (wr_x),
    .wr_y                    (wr_y),
    .wr_data                 (wr_data),
    .sram_addr               (sram_addr),
    .sram_we                 (sram_we),
    .sram_wdata              (sram_wdata),
    .sram_rdata              (sram_rdata),
    .wfifo_level             (wfifo_level),
    .dropped_writes          (dropped_writes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM environment (two-cycle read pipeline) ----------------
  logic [15:0] env_mem [int];
  logic [15:0] ref_mem [int];
  logic [15:0] p1;
  logic [15:0] p2;

  function automatic logic [15:0] sram_init(input int a);
    return 16'(a) ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] env_rd(input int a);
    return env_mem.exists(a) ? env_mem[a] : sram_init(a);
  endfunction

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : sram_init(a);
  endfunction

  task automatic preload(input int a, input logic [15:0] d);
    env_mem[a] = d;
    ref_mem[a] = d;
  endtask

  always @(posedge clk) begin
    p1 <= env_rd(int'(sram_addr));
    p2 <= p1;
    if (sram_we) env_mem[int'(sram_addr)] = sram_wdata;
  end
  assign sram_rdata = p2;

  // ---------------- Reference model ----------------
  typedef struct { int addr; logic [15:0] data; } wr_t;
  wr_t         fifo_q[$];
  bit          resp_v[$];
  logic [15:0] resp_d[$];

  logic [15:0] exp_data;
  bit          exp_skip;
  bit          exp_we;
  int          exp_addr;
  logic [15:0] exp_wdata;
  int          exp_drop;
  int          exp_level;
  bit          exp_ready;

  task automatic model_reset();
    fifo_q.delete();
    resp_v.delete();
    resp_d.delete();
    for (int i = 0; i <= RL; i++) begin
      resp_v.push_back(1'b0);
      resp_d.push_back(16'h0000);
    end
    exp_data = 16'h0000; exp_skip = 1'b1; exp_we = 1'b0; exp_addr = 0;
    exp_wdata = 16'h0000; exp_drop = 0; exp_level = 0; exp_ready = 1'b1;
  endtask

  task automatic model_step();
    int  rx, ry, wx, wy;
    bit  hit, do_pop, can_push;
    wr_t e;
    rx  = int'($signed(req_x));
    ry  = int'($signed(req_y));
    hit = req_active && rx >= 0 && rx < RES_X && ry >= 0 && ry < RES_Y;
    resp_v.push_back(hit);
    resp_d.push_back(hit ? ref_rd(ry * RES_X + rx) : 16'h0000);
    exp_skip = !resp_v.pop_front();
    exp_data = resp_d.pop_front();

    do_pop   = !hit && fifo_q.size() > 0;
    can_push = fifo_q.size() < DEPTH;
    exp_we   = 1'b0;
    if (do_pop) begin
      e = fifo_q.pop_front();
      ref_mem[e.addr] = e.data;
      exp_we = 1'b1; exp_addr = e.addr; exp_wdata = e.data;
    end else if (hit) begin
      exp_addr = ry * RES_X + rx;
    end

    if (wr_valid && can_push) begin
      wx = int'(wr_x);
      wy = int'(wr_y);
      if (wx < RES_X && wy < RES_Y) begin
        e.addr = wy * RES_X + wx;
        e.data = wr_data;
        fifo_q.push_back(e);
      end else if (exp_drop < 65535) begin
        exp_drop++;
      end
    end
    exp_level = fifo_q.size();
    exp_ready = fifo_q.size() < DEPTH;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // One compare per cycle, well after the edge settles.
  always @(posedge clk) begin
    #1;
    if (model_on) begin
      chk("m_skip",  fg_pixel_skip, exp_skip);
      chk("m_data",  fg_pixel_data, exp_data);
      chk("m_we",    sram_we, exp_we);
      chk("m_addr",  sram_addr, exp_addr);
      if (exp_we) chk("m_wdata", sram_wdata, exp_wdata);
      chk("m_ready", wr_ready, exp_ready);
      chk("m_level", wfifo_level, exp_level);
      chk("m_drop",  dropped_writes, exp_drop);
    end
  end

  // ---------------- Directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input bit a, input int x, input int y);
    req_active = a;
    req_x      = 13'(x);
    req_y      = 13'(y);
  endtask

  task automatic wr(input bit v, input int x, input int y, input logic [15:0] d);
    wr_valid = v;
    wr_x     = 12'(x);
    wr_y     = 12'(y);
    wr_data  = d;
  endtask

  int          xs [4] = '{-1, 1920, 0, 1919};
  int          ys [4] = '{0, 0, 1080, 1079};
  logic [15:0] wd [3] = '{16'h1111, 16'h2222, 16'h3333};
  int          we_seen;

  initial begin
    rd(0, 0, 0);
    wr(0, 0, 0, 16'h0000);
    preload(3845, 16'hBEEF);
    preload(2073599, 16'h1234);
    repeat (2) tick();
    rst = 1'b0;
    model_on = 1'b1;
    chk("rst_skip", fg_pixel_skip, 1);
    chk("rst_data", fg_pixel_data, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_level", wfifo_level, 0);
    chk("rst_drop", dropped_writes, 0);

    // Single in-range read: address, raw SRAM data, response four cycles on.
    rd(1, 5, 2);
    tick();
    chk("t1_addr", sram_addr, 3845);
    chk("t1_we", sram_we, 0);
    rd(0, 0, 0);
    repeat (2) tick();
    chk("t1_rdata", sram_rdata, 16'hBEEF);
    tick();
    chk("t1_data", fg_pixel_data, 16'hBEEF);
    chk("t1_skip", fg_pixel_skip, 0);

    // Out-of-range edges then the last valid pixel.
    for (int i = 0; i < 4; i++) begin
      rd(1, xs[i], ys[i]);
      tick();
      if (i < 3) begin
        chk("t2_noread_we", sram_we, 0);
        chk("t2_noread_addr", sram_addr, 3845);
      end
    end
    rd(0, 0, 0);
    chk("t2_addr", sram_addr, 2073599);
    chk("t2_r0_skip", fg_pixel_skip, 1);
    chk("t2_r0_data", fg_pixel_data, 0);
    repeat (2) tick();
    chk("t2_r2_skip", fg_pixel_skip, 1);
    tick();
    chk("t2_r3_data", fg_pixel_data, 16'h1234);
    chk("t2_r3_skip", fg_pixel_skip, 0);

    // Writes held off by reads, then drained in order.
    for (int i = 0; i < 5; i++) begin
      rd(1, 100 + i, 3);
      if (i < 3) wr(1, 10 + i, 0, wd[i]);
      else       wr(0, 0, 0, 16'h0000);
      tick();
    end
    chk("t3_level", wfifo_level, 3);
    chk("t3_held_we", sram_we, 0);
    rd(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_we", sram_we, 1);
      chk("t3_addr", sram_addr, 10 + i);
      chk("t3_wdata", sram_wdata, wd[i]);
    end
    tick();
    chk("t3_we_end", sram_we, 0);
    chk("t3_level_end", wfifo_level, 0);
    rd(1, 11, 0);
    tick();
    rd(0, 0, 0);
    repeat (3) tick();
    chk("t3_readback", fg_pixel_data, 16'h2222);

    // Fill to full under continuous reads, then free one slot.
    for (int i = 0; i < 16; i++) begin
      rd(1, 7, 7);
      wr(1, 100 + i, 20, 16'h4000 + 16'(i));
      tick();
    end
    chk("t4_level_full", wfifo_level, 16);
    chk("t4_ready_full", wr_ready, 0);
    wr(1, 116, 20, 16'h4010);
    tick();
    chk("t4_level_hold", wfifo_level, 16);
    rd(0, 0, 0);
    wr(0, 0, 0, 16'h0000);
    tick();
    chk("t4_level_pop", wfifo_level, 15);
    chk("t4_ready_pop", wr_ready, 1);
    chk("t4_pop_addr", sram_addr, 38500);
    repeat (16) tick();
    chk("t4_drained", wfifo_level, 0);

    // Out-of-range writes are accepted and counted, never stored.
    rd(1, 9, 9);
    wr(1, 1920, 5, 16'hDEAD);
    #1;
    chk("t5_ready", wr_ready, 1);
    tick();
    chk("t5_drop1", dropped_writes, 1);
    chk("t5_level", wfifo_level, 0);
    wr(1, 5, 1080, 16'hBEAD);
    tick();
    chk("t5_drop2", dropped_writes, 2);
    rd(0, 0, 0);
    wr(0, 0, 0, 16'h0000);
    tick();
    chk("t5_no_write", sram_we, 0);

    // Reset with reads in flight and writes queued.
    for (int i = 0; i < 5; i++) begin
      rd(1, 200 + i, 30);
      wr(1, 200 + i, 30, 16'h6000 + 16'(i));
      tick();
    end
    wr(0, 0, 0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      rd(1, 300 + i, 40);
      tick();
    end
    chk("t6_level_pre", wfifo_level, 5);
    rst = 1'b1;
    #1;
    chk("t6_skip", fg_pixel_skip, 1);
    chk("t6_data", fg_pixel_data, 0);
    chk("t6_level", wfifo_level, 0);
    chk("t6_we", sram_we, 0);
    chk("t6_drop", dropped_writes, 0);
    chk("t6_ready", wr_ready, 1);
    rd(0, 0, 0);
    tick();
    rst = 1'b0;
    we_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (sram_we) we_seen++;
    end
    chk("t6_no_writes", we_seen, 0);
    chk("t6_skip_after", fg_pixel_skip, 1);

    // Normal operation resumes after reset.
    rd(1, 0, 0);
    tick();
    rd(0, 0, 0);
    repeat (3) tick();
    chk("t7_data", fg_pixel_data, 16'hA5C3);
    chk("t7_skip", fg_pixel_skip, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
